io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
- CPU-side initiator for the 8-bit IO port bus. Drives the address, write data and RE/WE strobes that the IO port peripheral responds to.
- Accepts one load/store request at a time from the core over a req/ack handshake.
- Sequences the bus through setup, strobe and hold phases with programmable lengths, captures read data, and flags out-of-range addresses (addr[7:3] != 0) without strobing the bus.

Parameters:
- SETUP_CYC, 1, cycles addr/wdata are stable before the strobe asserts (1..15)
- STROBE_CYC, 2, cycles RE or WE is held high (1..15)
- HOLD_CYC, 1, cycles addr/wdata stay stable after the strobe drops (0..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  core request valid; sampled only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  8  IO address
- req_wdata  in  8  write data
- busy  out  1  high from request acceptance until ack
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = address out of IO range
- rdata  out  8  read result, valid with ack, held until next ack
- bus_addr  out  8  address to IO port
- bus_wdata  out  8  data to IO port Din
- bus_re  out  1  read strobe
- bus_we  out  1  write strobe
- bus_rdata  in  8  data from IO port Dout

Behaviour:
- Reset (async, rst_n low): state IDLE. busy, ack, err, bus_re and bus_we are 0. rdata, bus_addr and bus_wdata are 8'h00. Counter is 0. Reset mid-transaction aborts it immediately with strobes low and no ack.
- All outputs are registered. bus_re and bus_we are never high in the same cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE, req=1:
  - Latch req_we, req_addr and req_wdata into bus_addr, bus_wdata and an internal we flag. Set busy=1.
  - If req_addr[7:3] != 0: go to DONE with err flagged. No strobe is ever driven.
  - Otherwise go to SETUP and load counter = SETUP_CYC-1.
- SETUP:
  - Strobes low. Decrement the counter; at 0 go to STROBE with counter = STROBE_CYC-1.
  - bus_re or bus_we asserts on the first STROBE cycle.
- STROBE:
  - bus_re = ~we, bus_we = we.
  - On the cycle the counter is 0 (last strobe cycle), a read samples bus_rdata into a capture register.
  - Next state is HOLD with counter = HOLD_CYC-1 if HOLD_CYC > 0, else DONE. Strobe deasserts on entry to the next state.
- HOLD: strobes low, bus_addr and bus_wdata unchanged. Decrement; at 0 go to DONE.
- DONE (one cycle):
  - ack=1 and busy=0 are registered on entry to DONE, so ack is visible in the DONE cycle.
  - rdata = captured data for a good read, 8'h00 for a write or an error. err=1 only for out-of-range.
  - Next state IDLE.
- Latency for an in-range access (req sampled at edge 0): ack high SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles later. Defaults give 5.
- Latency for an out-of-range access: ack 1 cycle after acceptance.
- req held high through ack starts a new transaction on the first IDLE cycle after DONE. There is no back-to-back acceptance in the DONE cycle. req changes while busy are ignored.
- bus_addr and bus_wdata keep their last values in IDLE; they are not forced to 0.
- The counter is 4 bits and never wraps: it is loaded only on phase entry and stops at 0.

Test Plan:
- Write, defaults: req=1, we=1, addr=8'h03, wdata=8'hA5 → bus_addr=03 and bus_wdata=A5 one cycle before bus_we. bus_we high exactly 2 cycles. ack 5 cycles after acceptance, err=0, rdata=00.
- Read, defaults: addr=8'h06, bus_rdata model returns 8'h3C during strobe → bus_re high 2 cycles, bus_we stays 0, ack with rdata=3C, err=0.
- Out of range: read addr=8'h08, then write addr=8'hFF → no strobe ever asserted. ack 1 cycle after acceptance, err=1, rdata=00.
- Back-to-back: req held high for two writes (addr 00 then 07) → second acceptance is in the IDLE cycle after ack. No overlap of strobes. Two ack pulses.
- Reset mid-strobe: assert rst_n low during the second bus_we cycle → bus_we drops asynchronously, no ack, busy=0. A fresh read after release completes normally.
- Parameter sweep: SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=0 → strobe width 1, ack 5 cycles after acceptance. Read data is captured in the single strobe cycle.

Source files
------------

// File: rtl/io_bus_master.sv
// CPU-side initiator for the 8-bit IO port bus: sequences setup, strobe and hold
// phases for one load/store at a time and returns read data with an ack pulse.
module io_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_re,
  output logic       bus_we,
  input  logic [7:0] bus_rdata
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          we_q, we_n;
  logic [DW-1:0] cap_q, cap_n;
  logic          busy_n, ack_n, err_n, re_n, wen_n;
  logic [DW-1:0] rdata_n, addr_n, wdata_n;
  logic          done_hit;

  // State and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      cap_q     <= '0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      we_q      <= we_n;
      cap_q     <= cap_n;
      busy      <= busy_n;
      ack       <= ack_n;
      err       <= err_n;
      rdata     <= rdata_n;
      bus_addr  <= addr_n;
      bus_wdata <= wdata_n;
      bus_re    <= re_n;
      bus_we    <= wen_n;
    end
  end

  // Next-state and next-output logic; strobes default low so they drop on phase exit
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    we_n     = we_q;
    cap_n    = cap_q;
    busy_n   = busy;
    ack_n    = 1'b0;
    err_n    = err;
    rdata_n  = rdata;
    addr_n   = bus_addr;
    wdata_n  = bus_wdata;
    re_n     = 1'b0;
    wen_n    = 1'b0;
    done_hit = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          addr_n  = req_addr;
          wdata_n = req_wdata;
          we_n    = req_we;
          if (|req_addr[7:3]) begin
            state_n = DONE;
            ack_n   = 1'b1;
            err_n   = 1'b1;
            rdata_n = '0;
            busy_n  = 1'b0;
          end else begin
            state_n = SETUP;
            cnt_n   = SETUP_LOAD;
            busy_n  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LOAD;
          re_n    = ~we_q;
          wen_n   = we_q;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (!we_q) cap_n = bus_rdata;
          if (HOLD_CYC > 0) begin
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
          end else begin
            done_hit = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
          re_n  = ~we_q;
          wen_n = we_q;
        end
      end
      HOLD: begin
        if (cnt == '0) done_hit = 1'b1;
        else           cnt_n = cnt - CW'(1);
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Completion of an in-range access; capture value may arrive on this same edge
    if (done_hit) begin
      state_n = DONE;
      ack_n   = 1'b1;
      busy_n  = 1'b0;
      err_n   = 1'b0;
      rdata_n = we_q ? '0 : cap_n;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: default-timing instance u0 and a
// SETUP=3/STROBE=1/HOLD=0 instance u1, checked by a negedge monitor.
module tb_io_bus_master;

  typedef struct {
    logic       we;
    logic       err;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
    int         strb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req[2], req_we[2];
  logic [7:0] req_addr[2], req_wdata[2], rd_val[2];
  logic       busy[2], ack[2], err[2], bus_re[2], bus_we[2];
  logic [7:0] rdata[2], bus_addr[2], bus_wdata[2], bus_rdata[2];

  int errors = 0;
  int checks = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  io_bus_master u0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]),
    .ack(ack[0]), .err(err[0]), .rdata(rdata[0]), .bus_addr(bus_addr[0]),
    .bus_wdata(bus_wdata[0]), .bus_re(bus_re[0]), .bus_we(bus_we[0]),
    .bus_rdata(bus_rdata[0])
  );

  io_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]),
    .ack(ack[1]), .err(err[1]), .rdata(rdata[1]), .bus_addr(bus_addr[1]),
    .bus_wdata(bus_wdata[1]), .bus_re(bus_re[1]), .bus_we(bus_we[1]),
    .bus_rdata(bus_rdata[1])
  );

  // IO port model: drives data only while read strobe is high
  assign bus_rdata[0] = bus_re[0] ? rd_val[0] : 8'hEE;
  assign bus_rdata[1] = bus_re[1] ? rd_val[1] : 8'hEE;

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sb_size(int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_head(int i);
    return (i == 0) ? sb0[0] : sb1[0];
  endfunction

  function automatic exp_t sb_pop(int i);
    return (i == 0) ? sb0.pop_front() : sb1.pop_front();
  endfunction

  // Monitor: latency from acceptance, strobe widths/addresses, ack payload
  int         lat_cnt[2], re_cnt[2], we_cnt[2];
  bit         active[2];
  logic [7:0] prev_addr[2];
  logic       prev_strb[2];

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        active[i]    = 1'b0;
        prev_strb[i] = 1'b0;
      end else begin
        if (active[i]) lat_cnt[i]++;
        if (bus_re[i] || bus_we[i]) begin
          chk("strobe_excl", 32'(bus_re[i] & bus_we[i]), 0);
          if (sb_size(i) == 0) begin
            chk("strobe_no_exp", sb_size(i), 1);
          end else begin
            e = sb_head(i);
            chk("strobe_addr", bus_addr[i], e.addr);
            if (e.we) chk("strobe_wdata", bus_wdata[i], e.wdata);
            if (!prev_strb[i]) chk("setup_addr", prev_addr[i], e.addr);
          end
          re_cnt[i] += int'(bus_re[i]);
          we_cnt[i] += int'(bus_we[i]);
        end
        if (ack[i]) begin
          if (sb_size(i) == 0) begin
            chk("ack_no_exp", sb_size(i), 1);
          end else begin
            e = sb_pop(i);
            chk("ack_err", err[i], e.err);
            chk("ack_rdata", rdata[i], e.rdata);
            chk("ack_busy", busy[i], 0);
            chk("ack_latency", lat_cnt[i], e.lat);
            chk("re_width", re_cnt[i], e.we ? 0 : e.strb);
            chk("we_width", we_cnt[i], e.we ? e.strb : 0);
          end
          active[i] = 1'b0;
        end else if (req[i] && !busy[i]) begin
          active[i]  = 1'b1;
          lat_cnt[i] = 0;
          re_cnt[i]  = 0;
          we_cnt[i]  = 0;
        end
        prev_addr[i] = bus_addr[i];
        prev_strb[i] = bus_re[i] | bus_we[i];
      end
    end
  end

  task automatic wait_ack(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[i] && n < 40);
    if (!ack[i]) chk("ack_timeout", ack[i], 1);
  endtask

  task automatic issue(int i, logic we, logic [7:0] a, logic [7:0] wd, logic [7:0] rd,
                       logic e_err, logic [7:0] e_rd, int lat, int strb, bit keep);
    exp_t e;
    e.we = we; e.err = e_err; e.addr = a; e.wdata = wd; e.rdata = e_rd;
    e.lat = lat; e.strb = strb;
    @(posedge clk); #1;
    req[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; rd_val[i] = rd;
    if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    wait_ack(i);
    if (!keep) begin
      @(posedge clk); #1;
      req[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 8'h00;
      req_wdata[i] = 8'h00; rd_val[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_ack", ack[i], 0);
      chk("rst_err", err[i], 0);
      chk("rst_re", bus_re[i], 0);
      chk("rst_we", bus_we[i], 0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_addr", bus_addr[i], 0);
      chk("rst_wdata", bus_wdata[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Default timing: write, read, two out-of-range, back-to-back writes
    issue(0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 8'h00, 5, 2, 1'b0);
    issue(0, 1'b0, 8'h06, 8'h00, 8'h3C, 1'b0, 8'h3C, 5, 2, 1'b0);
    issue(0, 1'b0, 8'h08, 8'h00, 8'h3C, 1'b1, 8'h00, 1, 0, 1'b0);
    issue(0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b1, 8'h00, 1, 0, 1'b0);
    issue(0, 1'b1, 8'h00, 8'hC3, 8'h00, 1'b0, 8'h00, 5, 2, 1'b1);
    issue(0, 1'b1, 8'h07, 8'h96, 8'h00, 1'b0, 8'h00, 5, 2, 1'b0);
    chk("idle_addr_kept", bus_addr[0], 8'h07);

    // Reset during the second write-strobe cycle
    e.we = 1'b1; e.err = 1'b0; e.addr = 8'h05; e.wdata = 8'h11; e.rdata = 8'h00;
    e.lat = 5; e.strb = 2;
    @(posedge clk); #1;
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h05; req_wdata[0] = 8'h11;
    sb0.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_we[0] && n < 20);
    chk("rst_we_first", bus_we[0], 1);
    @(negedge clk);
    chk("rst_we_second", bus_we[0], 1);
    chk("rst_busy_before", busy[0], 1);
    #1;
    rst_n = 1'b0;
    req[0] = 1'b0;
    sb0.delete();
    #1;
    chk("rst_async_we", bus_we[0], 0);
    chk("rst_async_busy", busy[0], 0);
    chk("rst_async_ack", ack[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 1'b0, 8'h02, 8'h00, 8'h5A, 1'b0, 8'h5A, 5, 2, 1'b0);

    // Short strobe, long setup, no hold
    issue(1, 1'b0, 8'h04, 8'h00, 8'hA7, 1'b0, 8'hA7, 5, 1, 1'b0);
    issue(1, 1'b1, 8'h01, 8'h77, 8'h00, 1'b0, 8'h00, 5, 1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
